// File: rtl/pc_flag_ctrl.sv
// pc_flag_ctrl: program-counter sequencer with registered N/Z flags.
//
// Steps a program counter from IDLE through RUN to DONE. Each unstalled RUN
// cycle retires one instruction: it either halts, takes a conditional
// relative branch, or falls through to pc+1. Compare opcodes update the N/Z
// flags, and branches test the registered flag values.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      level request: IDLE->RUN when high, DONE->IDLE when low
//   stall      freezes all RUN state for the cycle
//   alu_op     opcode of the executing instruction (0110/0111 write flags)
//   alu_neg    less-than result for the executing instruction
//   alu_zero   equal result for the executing instruction
//   br_en      executing instruction is a branch
//   br_cond    00 always, 01 N, 10 Z, 11 !N && !Z
//   br_off     signed 8-bit pc offset
//   halt       executing instruction ends the program
//   pc         fetch address
//   flag_n     registered N flag
//   flag_z     registered Z flag
//   taken      one-cycle pulse following a taken branch
//   done       high while in DONE
//   instr_cnt  saturating retired-instruction count
module pc_flag_ctrl #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic [3:0]       alu_op,
    input  logic             alu_neg,
    input  logic             alu_zero,
    input  logic             br_en,
    input  logic [1:0]       br_cond,
    input  logic [7:0]       br_off,
    input  logic             halt,
    output logic [PC_W-1:0]  pc,
    output logic             flag_n,
    output logic             flag_z,
    output logic             taken,
    output logic             done,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [PC_W-1:0]  pc_nx;
    logic             flag_n_nx, flag_z_nx, taken_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             cond_ok;
    logic [PC_W-1:0]  off_ext;

    // Sign-extend the offset to pc width; the add then wraps mod 2^PC_W.
    assign off_ext = PC_W'($signed(br_off));

    // Conditions look only at the registered flags, never at this cycle's ALU.
    always_comb begin
        cond_ok = 1'b0;
        case (br_cond)
            2'b00: cond_ok = 1'b1;
            2'b01: cond_ok = flag_n;
            2'b10: cond_ok = flag_z;
            2'b11: cond_ok = !flag_n && !flag_z;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        flag_n_nx = flag_n;
        flag_z_nx = flag_z;
        taken_nx  = 1'b0;
        cnt_nx    = instr_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = RUN;
                    pc_nx     = '0;
                    flag_n_nx = 1'b0;
                    flag_z_nx = 1'b0;
                    cnt_nx    = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (instr_cnt != '1)
                        cnt_nx = instr_cnt + CNT_W'(1);
                    if (alu_op == 4'b0110 || alu_op == 4'b0111) begin
                        flag_n_nx = alu_neg;
                        flag_z_nx = alu_zero;
                    end
                    if (halt) begin
                        state_nx = DONE;
                    end else if (br_en && cond_ok) begin
                        pc_nx    = pc + off_ext;
                        taken_nx = 1'b1;
                    end else begin
                        pc_nx = pc + PC_W'(1);
                    end
                end
            end
            DONE: begin
                if (!start)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            taken     <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            flag_n    <= flag_n_nx;
            flag_z    <= flag_z_nx;
            taken     <= taken_nx;
            instr_cnt <= cnt_nx;
        end
    end

    assign done = (state == DONE);

endmodule

// File: tb/tb_pc_flag_ctrl.sv
// Directed table-driven bench for pc_flag_ctrl. A second instance with a
// 2-bit counter shares all inputs so counter saturation is reachable quickly.
module tb_pc_flag_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stall, alu_neg, alu_zero, br_en, halt;
    logic [3:0] alu_op;
    logic [1:0] br_cond;
    logic [7:0] br_off;

    logic [9:0]  pc,  pc_s;
    logic        flag_n, flag_z, taken, done;
    logic        flag_n_s, flag_z_s, taken_s, done_s;
    logic [15:0] instr_cnt;
    logic [1:0]  instr_cnt_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_flag_ctrl #(.PC_W(10), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .alu_op(alu_op), .alu_neg(alu_neg), .alu_zero(alu_zero),
        .br_en(br_en), .br_cond(br_cond), .br_off(br_off), .halt(halt),
        .pc(pc), .flag_n(flag_n), .flag_z(flag_z), .taken(taken),
        .done(done), .instr_cnt(instr_cnt)
    );

    pc_flag_ctrl #(.PC_W(10), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .alu_op(alu_op), .alu_neg(alu_neg), .alu_zero(alu_zero),
        .br_en(br_en), .br_cond(br_cond), .br_off(br_off), .halt(halt),
        .pc(pc_s), .flag_n(flag_n_s), .flag_z(flag_z_s), .taken(taken_s),
        .done(done_s), .instr_cnt(instr_cnt_s)
    );

    typedef struct {
        logic        st, stl;
        logic [3:0]  op;
        logic        neg, zero, br;
        logic [1:0]  cond;
        logic [7:0]  off;
        logic        hlt;
        logic [9:0]  epc;
        logic        en, ez, etk, edn;
        logic [15:0] ecnt;
    } vec_t;

    function automatic vec_t v(input logic st, input logic stl, input logic [3:0] op,
                               input logic neg, input logic zero, input logic br,
                               input logic [1:0] cond, input logic [7:0] off, input logic hlt,
                               input logic [9:0] epc, input logic en, input logic ez,
                               input logic etk, input logic edn, input logic [15:0] ecnt);
        vec_t r;
        r.st = st; r.stl = stl; r.op = op; r.neg = neg; r.zero = zero; r.br = br;
        r.cond = cond; r.off = off; r.hlt = hlt; r.epc = epc; r.en = en; r.ez = ez;
        r.etk = etk; r.edn = edn; r.ecnt = ecnt;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t t);
        int sat;
        sat = (t.ecnt > 16'd3) ? 3 : int'(t.ecnt);
        chk({tag, ".pc"},      int'(pc),          int'(t.epc));
        chk({tag, ".flag_n"},  int'(flag_n),      int'(t.en));
        chk({tag, ".flag_z"},  int'(flag_z),      int'(t.ez));
        chk({tag, ".taken"},   int'(taken),       int'(t.etk));
        chk({tag, ".done"},    int'(done),        int'(t.edn));
        chk({tag, ".cnt"},     int'(instr_cnt),   int'(t.ecnt));
        chk({tag, ".cnt_sat"}, int'(instr_cnt_s), sat);
    endtask

    task automatic run_vec(input string tag, input vec_t t);
        start = t.st; stall = t.stl; alu_op = t.op; alu_neg = t.neg;
        alu_zero = t.zero; br_en = t.br; br_cond = t.cond; br_off = t.off;
        halt = t.hlt;
        @(posedge clk);
        #1;
        chk_all(tag, t);
    endtask

    vec_t tbl[19];
    vec_t zero_v;

    initial begin
        //           st stl op    n  z  br cond off    h   pc    N  Z  tk dn cnt
        tbl[0]  = v(1, 0, 4'h0, 0, 0, 0, 2'd0, 8'h00, 0, 10'd0, 0, 0, 0, 0, 16'd0);
        tbl[1]  = v(1, 0, 4'h0, 0, 0, 0, 2'd0, 8'h00, 0, 10'd1, 0, 0, 0, 0, 16'd1);
        tbl[2]  = v(0, 0, 4'h0, 0, 0, 0, 2'd0, 8'h00, 0, 10'd2, 0, 0, 0, 0, 16'd2);
        tbl[3]  = v(0, 0, 4'h0, 0, 0, 0, 2'd0, 8'h00, 0, 10'd3, 0, 0, 0, 0, 16'd3);
        tbl[4]  = v(0, 0, 4'h7, 0, 1, 0, 2'd0, 8'h00, 0, 10'd4, 0, 1, 0, 0, 16'd4);
        tbl[5]  = v(0, 1, 4'h7, 1, 0, 1, 2'd0, 8'h05, 0, 10'd4, 0, 1, 0, 0, 16'd4);
        tbl[6]  = v(0, 1, 4'h7, 1, 0, 1, 2'd0, 8'h05, 1, 10'd4, 0, 1, 0, 0, 16'd4);
        tbl[7]  = v(0, 0, 4'h6, 1, 0, 0, 2'd0, 8'h00, 0, 10'd5, 1, 0, 0, 0, 16'd5);
        tbl[8]  = v(0, 0, 4'h0, 0, 0, 1, 2'd1, 8'hFE, 0, 10'd3, 1, 0, 1, 0, 16'd6);
        tbl[9]  = v(0, 0, 4'h0, 0, 0, 0, 2'd0, 8'h00, 0, 10'd4, 1, 0, 0, 0, 16'd7);
        tbl[10] = v(0, 0, 4'h0, 0, 0, 0, 2'd0, 8'h00, 0, 10'd5, 1, 0, 0, 0, 16'd8);
        tbl[11] = v(0, 0, 4'h0, 0, 0, 0, 2'd0, 8'h00, 0, 10'd6, 1, 0, 0, 0, 16'd9);
        tbl[12] = v(0, 0, 4'h0, 0, 0, 0, 2'd0, 8'h00, 0, 10'd7, 1, 0, 0, 0, 16'd10);
        tbl[13] = v(0, 0, 4'h0, 0, 0, 1, 2'd2, 8'h0A, 0, 10'd8, 1, 0, 0, 0, 16'd11);
        // flag write and Z-branch in one cycle: branch still sees old Z=0
        tbl[14] = v(0, 0, 4'h6, 0, 1, 1, 2'd2, 8'h03, 0, 10'd9, 0, 1, 0, 0, 16'd12);
        tbl[15] = v(1, 0, 4'h0, 0, 0, 1, 2'd0, 8'h05, 1, 10'd9, 0, 1, 0, 1, 16'd13);
        tbl[16] = v(1, 0, 4'h6, 1, 0, 1, 2'd0, 8'h05, 1, 10'd9, 0, 1, 0, 1, 16'd13);
        tbl[17] = v(0, 0, 4'h6, 1, 0, 1, 2'd0, 8'h05, 1, 10'd9, 0, 1, 0, 0, 16'd13);
        tbl[18] = v(0, 0, 4'h6, 1, 0, 1, 2'd0, 8'h05, 1, 10'd9, 0, 1, 0, 0, 16'd13);

        zero_v = v(0, 0, 4'h0, 0, 0, 0, 2'd0, 8'h00, 0, 10'd0, 0, 0, 0, 0, 16'd0);

        reset = 1'b1; start = 1'b0; stall = 1'b0; alu_op = 4'h0; alu_neg = 1'b0;
        alu_zero = 1'b0; br_en = 1'b0; br_cond = 2'd0; br_off = 8'h00; halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", zero_v);
        reset = 1'b0;

        for (int i = 0; i < 19; i++)
            run_vec($sformatf("v%0d", i), tbl[i]);

        // second program: self-loop, !N&&!Z branch, wrap to 1023 and back to 0
        run_vec("s_start", v(1, 0, 4'h0, 0, 0, 0, 2'd0, 8'h00, 0, 10'd0,    0, 0, 0, 0, 16'd0));
        run_vec("s_self",  v(0, 0, 4'h0, 0, 0, 1, 2'd0, 8'h00, 0, 10'd0,    0, 0, 1, 0, 16'd1));
        run_vec("s_c11",   v(0, 0, 4'h0, 0, 0, 1, 2'd3, 8'h05, 0, 10'd5,    0, 0, 1, 0, 16'd2));
        run_vec("s_neg",   v(0, 0, 4'h0, 0, 0, 1, 2'd0, 8'hFA, 0, 10'd1023, 0, 0, 1, 0, 16'd3));
        run_vec("s_wrap",  v(0, 0, 4'h0, 0, 0, 0, 2'd0, 8'h00, 0, 10'd0,    0, 0, 0, 0, 16'd4));
        run_vec("s_setn",  v(0, 0, 4'h6, 1, 0, 0, 2'd0, 8'h00, 0, 10'd1,    1, 0, 0, 0, 16'd5));
        run_vec("s_c11nt", v(0, 0, 4'h0, 0, 0, 1, 2'd3, 8'h05, 0, 10'd2,    1, 0, 0, 0, 16'd6));
        run_vec("s_take",  v(0, 0, 4'h0, 0, 0, 1, 2'd1, 8'h10, 0, 10'd18,   1, 0, 1, 0, 16'd7));

        // asynchronous reset mid-RUN, observed before the next edge
        reset = 1'b1;
        #1;
        chk_all("async_rst", zero_v);
        @(negedge clk);
        reset = 1'b0;
        run_vec("idle0", v(0, 0, 4'h6, 1, 1, 1, 2'd0, 8'h05, 1, 10'd0, 0, 0, 0, 0, 16'd0));
        run_vec("idle1", v(0, 0, 4'h7, 1, 1, 1, 2'd0, 8'h05, 1, 10'd0, 0, 0, 0, 0, 16'd0));
        run_vec("rerun0", v(1, 0, 4'h0, 0, 0, 0, 2'd0, 8'h00, 0, 10'd0, 0, 0, 0, 0, 16'd0));
        run_vec("rerun1", v(1, 0, 4'h0, 0, 0, 0, 2'd0, 8'h00, 0, 10'd1, 0, 0, 0, 0, 16'd1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
